// File: rtl/fir_tdm_mc.sv
// fir_tdm_mc: time-multiplexed multi-channel FIR, one shared signed MAC,
// runtime coefficients, per-channel delay lines, saturating output.
module fir_tdm_mc #(
  parameter int width_H = 5,
  parameter int width_W = 20,
  parameter int N = 32,
  parameter int CH = 1,
  localparam int DW = width_H + width_W,
  localparam int CW = (CH > 1) ? $clog2(CH) : 1,
  localparam int AW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  input  logic [CW-1:0] s_ch,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic [CW-1:0] m_ch,
  output logic          m_sat,
  input  logic          coef_we,
  input  logic [AW-1:0] coef_addr,
  input  logic [DW-1:0] coef_data,
  output logic          coef_ready
);

  localparam int G = $clog2(N + 1) + 1;
  localparam int ACCW = DW + G;
  localparam int PW = 2 * DW;
  localparam int KW = $clog2(N + 2);
  localparam int DL = CH * (N + 1);
  localparam int LW = (DL > 1) ? $clog2(DL) : 1;
  localparam int NCH = 2 ** CW;

  localparam logic signed [ACCW-1:0] MAXV =
    {{(G + 1){1'b0}}, {(DW - 1){1'b1}}};
  localparam logic signed [ACCW-1:0] MINV =
    {{(G + 1){1'b1}}, {(DW - 1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  state_t state, state_nx;

  logic signed [DW-1:0] coef [N+1];
  logic signed [DW-1:0] dline [DL];
  logic [AW-1:0] wptr [NCH];

  logic [CW-1:0] ch_q;
  logic [AW-1:0] rd_q;
  logic [KW-1:0] k_q;
  logic signed [DW-1:0] prod_q;
  logic signed [ACCW-1:0] acc_q;

  logic ch_ok;
  logic take;
  logic coef_wr;
  logic last;
  logic [LW-1:0] wr_idx;
  logic [LW-1:0] rd_idx;
  logic [AW-1:0] tap;
  logic signed [PW-1:0] full;
  logic signed [DW-1:0] prod;
  logic signed [ACCW-1:0] sum;
  logic sat_hi;
  logic sat_lo;

  assign ch_ok = int'(s_ch) < CH;
  assign take = s_valid && s_ready && ch_ok;
  assign coef_wr = coef_we && coef_ready &&
    ({1'b0, coef_addr} <= (AW + 1)'(N));

  // One extra MAC edge drains the registered product into the sum.
  assign last = (k_q == KW'(N + 1));

  assign wr_idx = LW'(s_ch) * LW'(N + 1) + LW'(wptr[s_ch]);
  assign rd_idx = LW'(ch_q) * LW'(N + 1) + LW'(rd_q);
  assign tap = (k_q > KW'(N)) ? '0 : AW'(k_q);

  assign full = PW'(dline[rd_idx]) * PW'(coef[tap]);
  assign prod = DW'(full >>> width_W);
  assign sum = acc_q + ACCW'(prod_q);

  assign sat_hi = sum > MAXV;
  assign sat_lo = sum < MINV;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    s_ready = 1'b0;
    coef_ready = 1'b0;
    unique case (state)
      IDLE: begin
        s_ready = !rst;
        coef_ready = !rst;
        if (s_valid && ch_ok && !rst) state_nx = MAC;
      end
      MAC: if (last) state_nx = OUT;
      OUT: if (m_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coef <= '{default: '0};
      dline <= '{default: '0};
      wptr <= '{default: '0};
      ch_q <= '0;
      rd_q <= '0;
      k_q <= '0;
      prod_q <= '0;
      acc_q <= '0;
      m_valid <= 1'b0;
      m_data <= '0;
      m_ch <= '0;
      m_sat <= 1'b0;
    end else begin
      if (coef_wr) coef[coef_addr] <= coef_data;
      if (take) begin
        dline[wr_idx] <= s_data;
        wptr[s_ch] <= (wptr[s_ch] == AW'(N)) ?
          '0 : wptr[s_ch] + AW'(1);
        ch_q <= s_ch;
        rd_q <= wptr[s_ch];
        k_q <= '0;
        prod_q <= '0;
        acc_q <= '0;
      end
      if (state == MAC) begin
        prod_q <= prod;
        acc_q <= sum;
        k_q <= k_q + KW'(1);
        rd_q <= (rd_q == '0) ? AW'(N) : rd_q - AW'(1);
        if (last) begin
          m_valid <= 1'b1;
          m_ch <= ch_q;
          m_sat <= sat_hi || sat_lo;
          m_data <= sat_hi ? MAXV[DW-1:0] :
                    sat_lo ? MINV[DW-1:0] : sum[DW-1:0];
        end
      end
      if (state == OUT && m_ready) m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_tdm_mc.sv
// tb_fir_tdm_mc: randomized scenarios against a direct-form
// shift-register reference model of the multi-channel FIR.
module tb_fir_tdm_mc;
  localparam int WH = 5;
  localparam int WW = 20;
  localparam int N = 32;
  localparam int CH = 2;
  localparam int DW = WH + WW;
  localparam int CW = 1;
  localparam int AW = 6;
  localparam longint MAXV = (longint'(1) << (DW - 1)) - 1;
  localparam longint MINV = -(longint'(1) << (DW - 1));

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic s_valid = 1'b0;
  logic s_ready;
  logic [DW-1:0] s_data = '0;
  logic [CW-1:0] s_ch = '0;
  logic m_valid;
  logic m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [CW-1:0] m_ch;
  logic m_sat;
  logic coef_we = 1'b0;
  logic [AW-1:0] coef_addr = '0;
  logic [DW-1:0] coef_data = '0;
  logic coef_ready;

  int vectors = 0;
  int errors = 0;

  longint mc [N+1];
  longint hist [CH][N+1];

  always #5 clk = ~clk;

  fir_tdm_mc #(
    .width_H(WH), .width_W(WW), .N(N), .CH(CH)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_ch(s_ch),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_ch(m_ch), .m_sat(m_sat),
    .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .coef_ready(coef_ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic longint sx(logic [DW-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint rnd_full();
    logic [DW-1:0] t;
    t = DW'($urandom);
    return sx(t);
  endfunction

  function automatic longint rnd_small(int bits);
    return longint'($urandom_range(0, (1 << bits) - 1))
      - (longint'(1) << (bits - 1));
  endfunction

  function automatic void m_reset();
    for (int i = 0; i <= N; i++) mc[i] = 0;
    for (int c = 0; c < CH; c++)
      for (int i = 0; i <= N; i++) hist[c][i] = 0;
  endfunction

  function automatic void m_coef(int a, longint d);
    if (a <= N) mc[a] = d;
  endfunction

  // y[n] = clamp( sum_k wrapDW( floor(x[n-k]*c[k] / 2^W) ) )
  function automatic void m_sample(int ch, longint x,
                                   output longint y, output bit sat);
    longint acc;
    longint p;
    for (int i = N; i > 0; i--) hist[ch][i] = hist[ch][i-1];
    hist[ch][0] = x;
    acc = 0;
    for (int k = 0; k <= N; k++) begin
      p = (hist[ch][k] * mc[k]) >>> WW;
      p = (p <<< (64 - DW)) >>> (64 - DW);
      acc += p;
    end
    sat = 1'b0;
    y = acc;
    if (acc > MAXV) begin y = MAXV; sat = 1'b1; end
    else if (acc < MINV) begin y = MINV; sat = 1'b1; end
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    s_valid = 1'b0;
    coef_we = 1'b0;
    m_ready = 1'b0;
    step();
    step();
    m_reset();
    rst = 1'b0;
    step();
  endtask

  task automatic load_coef(int a, longint d);
    coef_we = 1'b1;
    coef_addr = AW'(a);
    coef_data = DW'(d);
    step();
    coef_we = 1'b0;
    m_coef(a, d);
  endtask

  task automatic send(int ch, longint d, output bit ok);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_ch = CW'(ch);
    s_data = DW'(d);
    while (!s_ready && n < 100) begin step(); n++; end
    ok = s_ready;
    step();
    s_valid = 1'b0;
  endtask

  task automatic get_result(int hold, output int lat, output bit to,
                            output longint y, output int ch,
                            output bit sat);
    lat = 0;
    while (!m_valid && lat < 200) begin step(); lat++; end
    to = !m_valid;
    y = sx(m_data);
    ch = int'(m_ch);
    sat = m_sat;
    repeat (hold) step();
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3 rst = 1'b1;
    step();
    vectors++;
    if (s_ready !== 1'b0 || coef_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: s_ready=%b coef_ready=%b want 0 0",
               s_ready, coef_ready);
    end
    vectors++;
    if (m_valid !== 1'b0 || m_data !== '0 || m_ch !== '0 ||
        m_sat !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: got v=%b d=%0d ch=%0d sat=%b want 0 0 0 0",
               m_valid, m_data, m_ch, m_sat);
    end
    m_reset();
    rst = 1'b0;
    step();
    vectors++;
    if (s_ready !== 1'b1 || coef_ready !== 1'b1 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got s=%b c=%b v=%b want 1 1 0",
               s_ready, coef_ready, m_valid);
    end
  endtask

  task automatic test_identity();
    bit ok, to, s, es;
    int lat, c;
    longint y, e;
    do_reset();
    load_coef(0, 1048576);
    send(0, 524288, ok);
    m_sample(0, 524288, e, es);
    get_result(0, lat, to, y, c, s);
    vectors++;
    if (!ok || to || lat != N + 2) begin
      errors++;
      $display("FAIL identity_latency: got %0d (ok=%b to=%b) want %0d",
               lat, ok, to, N + 2);
    end
    vectors++;
    if (y !== 524288 || y !== e || s !== 1'b0 || c != 0) begin
      errors++;
      $display("FAIL identity_data: got %0d sat=%b ch=%0d want 524288 0 0",
               y, s, c);
    end
  endtask

  task automatic test_impulse();
    bit ok, to, s, es;
    int lat, c;
    longint y, e, x;
    do_reset();
    for (int k = 0; k <= N; k++) load_coef(k, k * 4096);
    for (int i = 0; i <= N; i++) begin
      x = (i == 0) ? 1048576 : 0;
      send(0, x, ok);
      m_sample(0, x, e, es);
      get_result(0, lat, to, y, c, s);
      vectors++;
      if (!ok || to || y !== longint'(i * 4096) || s !== 1'b0) begin
        errors++;
        $display("FAIL impulse[%0d]: got %0d sat=%b want %0d sat=0",
                 i, y, s, i * 4096);
      end
    end
  endtask

  task automatic test_saturation();
    bit ok, to, s, es;
    int lat, c;
    longint y, e, x;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      for (int k = 0; k <= N; k++) load_coef(k, 1048576);
      x = (pass == 0) ? 1048576 : -1048576;
      for (int i = 1; i <= 17; i++) begin
        send(0, x, ok);
        m_sample(0, x, e, es);
        get_result(0, lat, to, y, c, s);
        vectors++;
        if (!ok || to || y !== e || s !== es) begin
          errors++;
          $display("FAIL sat_step[%0d,%0d]: got %0d sat=%b want %0d sat=%b",
                   pass, i, y, s, e, es);
        end
        if (pass == 0 && i == 16) begin
          vectors++;
          if (y !== 16777215 || s !== 1'b1) begin
            errors++;
            $display("FAIL sat_pos16: got %0d sat=%b want 16777215 sat=1",
                     y, s);
          end
        end
        if (pass == 1 && i >= 16) begin
          vectors++;
          if (y !== -16777216 || s !== (i == 17)) begin
            errors++;
            $display("FAIL sat_neg%0d: got %0d sat=%b want -16777216 sat=%0d",
                     i, y, s, i == 17);
          end
        end
      end
    end
  endtask

  task automatic test_channels();
    bit ok, to, s, es;
    int lat, c, n0, n1, ch;
    longint y, e, x;
    do_reset();
    load_coef(0, 1048576);
    n0 = 0;
    n1 = 0;
    while (n0 < 12 || n1 < 12) begin
      if (n0 >= 12) ch = 1;
      else if (n1 >= 12) ch = 0;
      else ch = int'($urandom_range(0, 1));
      if (ch == 0) begin x = (n0 == 0) ? 1048576 : 0; n0++; end
      else begin x = 524288; n1++; end
      send(ch, x, ok);
      m_sample(ch, x, e, es);
      get_result(0, lat, to, y, c, s);
      vectors++;
      if (!ok || to || y !== e || y !== x || c != ch || s !== 1'b0) begin
        errors++;
        $display("FAIL channels: got %0d ch=%0d sat=%b want %0d ch=%0d sat=0",
                 y, c, s, e, ch);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok, to, s, es;
    int lat, c;
    longint y, e, x;
    do_reset();
    for (int k = 0; k <= N; k++) load_coef(k, rnd_small(20));
    x = rnd_small(22);
    send(0, x, ok);
    m_sample(0, x, e, es);
    lat = 0;
    while (!m_valid && lat < 200) begin step(); lat++; end
    vectors++;
    if (!ok || m_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_valid: got m_valid=%b want 1", m_valid);
    end
    for (int i = 0; i < 10; i++) begin
      coef_we = 1'b1;
      coef_addr = AW'(i);
      coef_data = DW'(rnd_small(22));
      step();
      vectors++;
      if (m_valid !== 1'b1 || sx(m_data) !== e || m_sat !== es ||
          s_ready !== 1'b0 || coef_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b d=%0d sat=%b s=%b c=%b want 1 %0d %b 0 0",
                 i, m_valid, sx(m_data), m_sat, s_ready, coef_ready, e, es);
      end
    end
    coef_we = 1'b0;
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    vectors++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got m_valid=%b want 0", m_valid);
    end
    x = rnd_small(22);
    send(0, x, ok);
    m_sample(0, x, e, es);
    get_result(0, lat, to, y, c, s);
    vectors++;
    if (!ok || to || y !== e || s !== es) begin
      errors++;
      $display("FAIL bp_next: got %0d sat=%b want %0d sat=%b", y, s, e, es);
    end
  endtask

  task automatic test_reset_mid_mac();
    bit ok, to, s, seen;
    int lat, c;
    longint y;
    do_reset();
    for (int k = 0; k <= N; k++) load_coef(k, rnd_small(21));
    send(1, rnd_small(23), ok);
    repeat (10) step();
    rst = 1'b1;
    step();
    vectors++;
    if (m_valid !== 1'b0 || s_ready !== 1'b0 || coef_ready !== 1'b0) begin
      errors++;
      $display("FAIL midmac_rst: got v=%b s=%b c=%b want 0 0 0",
               m_valid, s_ready, coef_ready);
    end
    step();
    rst = 1'b0;
    m_reset();
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (m_valid !== 1'b0) seen = 1'b1;
    end
    vectors++;
    if (seen || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL midmac_pulse: got seen=%b s_ready=%b want 0 1",
               seen, s_ready);
    end
    send(1, rnd_full(), ok);
    get_result(0, lat, to, y, c, s);
    vectors++;
    if (!ok || to || y !== 0 || s !== 1'b0 || c != 1) begin
      errors++;
      $display("FAIL midmac_zero: got %0d sat=%b ch=%0d want 0 0 1", y, s, c);
    end
  endtask

  task automatic test_random();
    bit ok, to, s, es, wr;
    int lat, c, ch, a;
    longint y, e, x, d;
    do_reset();
    for (int k = 0; k <= N; k++) load_coef(k, rnd_small(21));
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 3) == 0)
        load_coef(int'($urandom_range(0, 63)), rnd_full());
      ch = int'($urandom_range(0, CH - 1));
      x = $urandom_range(0, 1) ? rnd_full() : rnd_small(19);
      wr = $urandom_range(0, 2) == 0;
      a = int'($urandom_range(0, 63));
      d = rnd_small(21);
      if (wr) begin
        coef_we = 1'b1;
        coef_addr = AW'(a);
        coef_data = DW'(d);
      end
      send(ch, x, ok);
      coef_we = 1'b0;
      if (wr) m_coef(a, d);
      m_sample(ch, x, e, es);
      if ($urandom_range(0, 1) == 1) begin
        coef_we = 1'b1;
        coef_addr = AW'($urandom_range(0, N));
        coef_data = DW'($urandom);
      end
      get_result(int'($urandom_range(0, 3)), lat, to, y, c, s);
      coef_we = 1'b0;
      vectors++;
      if (!ok || to || y !== e || s !== es || c != ch) begin
        errors++;
        $display("FAIL random[%0d]: got %0d sat=%b ch=%0d want %0d sat=%b ch=%0d",
                 t, y, s, c, e, es, ch);
      end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_impulse();
    test_saturation();
    test_channels();
    test_backpressure();
    test_reset_mid_mac();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
